qam_tx_symbol_source: RTL
=========================

// Module: qam_tx_symbol_source
// PURPOSE
//  Transmit end of the 16-QAM MER test link. Per channel (I and Q) it generates a PRBS-driven 2-bit symbol,
//  maps it to a Gray-coded 4-ASK level in 1s17 format, and zero-stuffs it onto the 4x sample grid.
//  Emits a frame_start pulse that marks each measurement window, which the receiver uses as its clear_accum.
//  Driven by the shared sym/smp clock enables; feeds the channel model / receiver slicer.
// PARAMETERS
//  SEED_I      22'h3FFFFF  I-channel LFSR reset seed (must be non-zero)
//  SEED_Q      22'h155555  Q-channel LFSR reset seed (must be non-zero, != SEED_I)
//  FRAME_LOG2  20          measurement window = 2**FRAME_LOG2 symbols
// PORTS
//  clk          in   1   system clock (single clock domain)
//  reset        in   1   synchronous, active-high reset
//  sym_clk_en   in   1   symbol-rate enable, 1 clk wide, coincides with every 4th smp_clk_en
//  smp_clk_en   in   1   sample-rate enable (4 samples/symbol)
//  tx_en        in   1   1 = run; 0 = freeze all state, outputs hold
//  sym_i/sym_q  out  2   current symbol bits per channel
//  map_out_i/q  out  18s mapped level (1s17), held for whole symbol
//  smp_out_i/q  out  18s zero-stuffed sample stream: level on symbol sample, 0 on other 3
//  sym_valid    out  1   1-clk pulse: new symbol on sym_*/map_out_*
//  frame_start  out  1   1-clk pulse with sym_valid on first symbol of each window
// BEHAVIOUR
//  - Reset: LFSRs<=SEED_I/SEED_Q; sym_*=2'b00; map_out_*,smp_out_*=0; sym_valid,frame_start=0;
//    symbol counter=0. Reset mid-operation aborts the window; first symbol after reset asserts frame_start.
//  - LFSR: 22-bit Fibonacci, x^22+x^21+1, advanced 2 steps per symbol; the 2 new bits form sym (MSB first).
//    All-zero state (corruption) is detected and reloaded with the seed on the same update.
//  - On clk edge with tx_en & sym_clk_en: LFSR steps, sym_*, map_out_* register new values (latency 1 clk),
//    sym_valid=1 next cycle; frame_start=1 iff symbol counter==0 before increment.
//  - Mapping (Gray): 00->-3a, 01->-a, 11->+a, 10->+3a; a=18'sd16384 (0.125), 3a=18'sd49152.
//  - smp_out: on tx_en & smp_clk_en & sym_clk_en load new mapped level; on tx_en & smp_clk_en & !sym_clk_en
//    load 0. Updated only on smp_clk_en edges; otherwise held.
//  - Symbol counter FRAME_LOG2 bits, increments per symbol, wraps 2**FRAME_LOG2-1 -> 0 (no stall).
//  - tx_en=0: no LFSR/counter/output update; sym_valid, frame_start forced 0; enables during this time are lost.
//  - sym_clk_en without smp_clk_en: treated as a protocol error; symbol still generated, smp_out unchanged.
// CONFIGURATION
//  `TX_SEED_LOAD_EN defined: adds ports seed_load (in,1) and seed_val (in,44: [43:22]=I, [21:0]=Q);
//    seed_load (priority below reset, above sym update) loads both LFSRs, clears counter; zero halves -> SEED_*.
//  Not defined: ports absent, LFSRs only ever loaded from SEED_I/SEED_Q.
// STRUCTURE
//  Package tx_sym_pkg: LFSR_W=22, tap positions, LVL_A/LVL_3A constants, Gray map function,
//    sample-format typedef (signed 18).
//  Sub-module prbs22_gen (instantiated twice): seed param, step enable, reload, 2-bit output.
//  Top holds mapper, zero-stuffer, symbol/frame counter.
// TESTING
//  1 Reset then 1 sym_clk_en: sym_i equals 2 bits from SEED_I stepped twice (golden model);
//    frame_start=1, sym_valid=1 one clk after.
//  2 Force each symbol 00/01/11/10 via golden LFSR: map_out = -49152/-16384/+16384/+49152.
//  3 Enables at 4 smp per sym: smp_out_i = level on sym sample, then exactly 3 zero samples.
//  4 FRAME_LOG2=4: frame_start on symbols 0,16,32; never elsewhere; counter wraps cleanly.
//  5 tx_en low for 40 clks mid-window: outputs hold, no pulses; sequence resumes at the next PRBS value.
//  6 Reset asserted mid-window: outputs zero next clk; first post-reset symbol equals test-1 value with frame_start.
//    With `TX_SEED_LOAD_EN, seed_load of 0 yields the SEED_* sequence.

Source files
------------

// File: rtl/qam_tx_symbol_source_pkg.sv
// Shared types, constants and the Gray 4-ASK mapper for the 16-QAM transmit symbol source.
package tx_sym_pkg;

    localparam int unsigned LFSR_W   = 22;
    localparam int unsigned TAP_A    = 21;
    localparam int unsigned TAP_B    = 20;
    localparam int unsigned SMP_W    = 18;
    localparam int unsigned SEED_V_W = 2 * LFSR_W;

    typedef logic signed [SMP_W-1:0] sample_t;

    localparam sample_t LVL_A  = 18'sd16384;
    localparam sample_t LVL_3A = 18'sd49152;

    // Gray order across the constellation: 00, 01, 11, 10 from most negative to most positive
    function automatic sample_t gray_map(input logic [1:0] sym);
        sample_t lvl;
        case (sym)
            2'b00:   lvl = -LVL_3A;
            2'b01:   lvl = -LVL_A;
            2'b11:   lvl = LVL_A;
            default: lvl = LVL_3A;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/qam_tx_symbol_source_if.sv
// Enable / symbol bus between the clock-enable source, the symbol source and its consumers.
// Seed-load signals exist only when TX_SEED_LOAD_EN is defined.
interface qam_tx_symbol_source_if;
    import tx_sym_pkg::*;

    logic                    sym_clk_en;
    logic                    smp_clk_en;
    logic                    tx_en;
    logic [1:0]              sym_i;
    logic [1:0]              sym_q;
    sample_t                 map_out_i;
    sample_t                 map_out_q;
    sample_t                 smp_out_i;
    sample_t                 smp_out_q;
    logic                    sym_valid;
    logic                    frame_start;
`ifdef TX_SEED_LOAD_EN
    logic                    seed_load;
    logic [SEED_V_W-1:0]     seed_val;
`endif

    modport master (
        input  sym_clk_en, smp_clk_en, tx_en,
`ifdef TX_SEED_LOAD_EN
        input  seed_load, seed_val,
`endif
        output sym_i, sym_q, map_out_i, map_out_q, smp_out_i, smp_out_q, sym_valid, frame_start
    );

    modport slave (
        output sym_clk_en, smp_clk_en, tx_en,
`ifdef TX_SEED_LOAD_EN
        output seed_load, seed_val,
`endif
        input  sym_i, sym_q, map_out_i, map_out_q, smp_out_i, smp_out_q, sym_valid, frame_start
    );

endinterface

// File: rtl/qam_tx_symbol_source_prbs22_gen.sv
// 22-bit Fibonacci PRBS (x^22+x^21+1) advanced two steps per enable; the two new bits are
// presented combinationally, first-generated bit in the MSB.
module prbs22_gen
    import tx_sym_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 22'h3FFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_step,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    output logic [1:0]        o_bits_c
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_s1;
    logic [LFSR_W-1:0] w_s2;
    logic              w_zero;

    assign w_zero   = (r_state == '0);
    assign w_s1     = {r_state[LFSR_W-2:0], r_state[TAP_A] ^ r_state[TAP_B]};
    assign w_s2     = {w_s1[LFSR_W-2:0], w_s1[TAP_A] ^ w_s1[TAP_B]};
    assign o_bits_c = w_zero ? 2'b00 : {w_s1[0], w_s2[0]};

    // A corrupted all-zero state would lock up; it is replaced by the seed on its next step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= (i_load_val == '0) ? SEED : i_load_val;
        end else if (i_step) begin
            r_state <= w_zero ? SEED : w_s2;
        end
    end

endmodule

// File: rtl/qam_tx_symbol_source.sv
// 16-QAM transmit symbol source: per-channel PRBS symbols, Gray 4-ASK mapping, 4x zero-stuffing
// and measurement-window framing. Optional runtime seed load under TX_SEED_LOAD_EN.
module qam_tx_symbol_source
    import tx_sym_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_I     = 22'h3FFFFF,
    parameter logic [LFSR_W-1:0] SEED_Q     = 22'h155555,
    parameter int unsigned       FRAME_LOG2 = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    qam_tx_symbol_source_if.master   bus
);

    logic                  w_load;
    logic [LFSR_W-1:0]     w_seed_i;
    logic [LFSR_W-1:0]     w_seed_q;
    logic                  w_sym_step;
    logic                  w_smp_step;
    logic [1:0]            w_bits_i;
    logic [1:0]            w_bits_q;
    sample_t               w_lvl_i;
    sample_t               w_lvl_q;
    logic [FRAME_LOG2-1:0] r_sym_cnt;

`ifdef TX_SEED_LOAD_EN
    assign w_load   = bus.seed_load;
    assign w_seed_i = bus.seed_val[SEED_V_W-1:LFSR_W];
    assign w_seed_q = bus.seed_val[LFSR_W-1:0];
`else
    assign w_load   = 1'b0;
    assign w_seed_i = SEED_I;
    assign w_seed_q = SEED_Q;
`endif

    // Seed load takes priority over symbol generation in the same cycle
    assign w_sym_step = bus.tx_en & bus.sym_clk_en & ~w_load;
    assign w_smp_step = bus.tx_en & bus.smp_clk_en & ~w_load;
    assign w_lvl_i    = gray_map(w_bits_i);
    assign w_lvl_q    = gray_map(w_bits_q);

    prbs22_gen #(.SEED(SEED_I)) u_prbs_i (
        .clk        (clk),
        .reset      (reset),
        .i_step     (w_sym_step),
        .i_load     (w_load),
        .i_load_val (w_seed_i),
        .o_bits_c   (w_bits_i)
    );

    prbs22_gen #(.SEED(SEED_Q)) u_prbs_q (
        .clk        (clk),
        .reset      (reset),
        .i_step     (w_sym_step),
        .i_load     (w_load),
        .i_load_val (w_seed_q),
        .o_bits_c   (w_bits_q)
    );

    // Symbol registers, mapper outputs and window framing
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.sym_i       <= 2'b00;
            bus.sym_q       <= 2'b00;
            bus.map_out_i   <= '0;
            bus.map_out_q   <= '0;
            bus.sym_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            r_sym_cnt       <= '0;
        end else begin
            bus.sym_valid   <= w_sym_step;
            bus.frame_start <= w_sym_step & (r_sym_cnt == '0);
            if (w_load) begin
                r_sym_cnt <= '0;
            end else if (w_sym_step) begin
                bus.sym_i     <= w_bits_i;
                bus.sym_q     <= w_bits_q;
                bus.map_out_i <= w_lvl_i;
                bus.map_out_q <= w_lvl_q;
                r_sym_cnt     <= r_sym_cnt + FRAME_LOG2'(1);
            end
        end
    end

    // Zero-stuffer: level on the symbol sample, zero on the other sample slots
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.smp_out_i <= '0;
            bus.smp_out_q <= '0;
        end else if (w_smp_step) begin
            bus.smp_out_i <= bus.sym_clk_en ? w_lvl_i : '0;
            bus.smp_out_q <= bus.sym_clk_en ? w_lvl_q : '0;
        end
    end

endmodule
